router_fifo_pkt: RTL and testbench
==================================

# router_fifo_pkt

Parametrised packet FIFO for the router output channels, successor to the fixed 16x8 channel FIFO. It stores DATA_W-bit bytes, each with a header-marker bit, and tracks packet boundaries on the read side. It adds occupancy and almost-full/almost-empty thresholds, sticky overflow/underflow flags, and a registered valid/last read interface in place of tri-stated output. One instance sits between the router register block (write side) and each destination port (read side).

## Interface
- DATA_W, 8, byte width; header length field is d_in[DATA_W-1:2]
- DEPTH, 16, entries; power of two, 4..256
- ADDR_W, $clog2(DEPTH), pointer index width (derived)
- AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- soft_rst  in  1  synchronous flush (timeout from sync block), active-high
- wr_en  in  1  write request
- lfd_state  in  1  header-load indicator; marks the byte written one cycle later
- d_in  in  DATA_W  write data
- rd_en  in  1  read request
- dout  out  DATA_W  read data, registered
- dout_valid  out  1  dout holds a word popped on the previous edge
- dout_last  out  1  with dout_valid: word is the packet's final (parity) byte
- full / empty  out  1  status, combinational from pointers
- almost_full / almost_empty  out  1  threshold status
- level  out  ADDR_W+1  occupancy 0..DEPTH
- overflow / underflow  out  1  sticky error flags

## Operation
- Storage: DEPTH x (DATA_W+1); bit DATA_W is the header marker.
- lfd_q is lfd_state registered; the write accepted on edge t uses lfd_q (lfd_state sampled at t-1) as its marker bit.
- Pointers wr_ptr, rd_ptr are ADDR_W+1 bits; index = low ADDR_W bits; wrap naturally.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits equal.
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Both use pre-edge full/empty.
- level: +1 on write only, -1 on read only, unchanged when both or neither are accepted. level == wr_ptr - rd_ptr at all times.
- Simultaneous read and write: allowed whenever neither is blocked. When full, the write is dropped even if a read is accepted the same edge. When empty, the read is dropped even if a write is accepted.
- Packet tracking, remaining counter rem (DATA_W bits), updated on each accepted read:
  - Popped word with marker = 1: rem <= word[DATA_W-1:2] + 1 (payload plus parity).
  - Else if rem != 0: rem <= rem - 1.
  - dout_last <= 1 iff the popped word is not a header and rem == 1 before the edge; else 0.
  - Header with length field 0: the next popped word is last.
- Read data: on an accepted read, dout <= payload bits of the entry and dout_valid <= 1. Otherwise dout_valid <= 0, dout_last <= 0, and dout holds its value.
- overflow <= 1 on wr_en && full. underflow <= 1 on rd_en && empty. Both cleared only by rst or soft_rst.
- soft_rst (priority below rst, above everything else): clears pointers, level, rem, lfd_q, dout, dout_valid, dout_last and both error flags. Memory contents are not cleared; they are unreachable after the pointer reset. wr_en/rd_en in the same cycle are ignored.
- rst: same clears as soft_rst. Memory contents are don't-care.

## Timing
- Reset values: dout = 0, dout_valid = 0, dout_last = 0, level = 0, overflow = 0, underflow = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Write-to-empty-deassert: 1 cycle (empty falls after the write edge).
- Read latency: rd_en sampled at edge t; dout/dout_valid valid after edge t, for one cycle.
- Back-to-back reads: one word per cycle, dout_valid held high.
- full, empty, almost_full, almost_empty, level all reflect state after the most recent edge. Thresholds are computed from level combinationally.
- Reset or soft_rst mid-packet: the next header read restarts tracking. A partial packet is discarded, with no dout_last.

## Test plan
- Reset: assert rst 2 cycles mid-traffic -> all outputs at reset values, level = 0, empty = 1.
- Packet: lfd_state = 1 one cycle before writing header 8'h0C, then 8'hA1, 8'hA2, 8'hA3 and parity 8'h5E; read 5 -> dout 0C,A1,A2,A3,5E on consecutive cycles, dout_valid high throughout, dout_last only on 5E.
- Fill/overflow (DEPTH = 16): 17 writes -> full after 16th, level = 16, almost_full from level 14, 17th dropped, overflow = 1. Read 16 -> data in order, empty, level = 0.
- Simultaneous: at level 16, rd_en & wr_en together -> read accepted, write dropped, level = 15. At level 5, both -> level stays 5, order preserved across pointer wrap.
- Underflow/soft_rst: rd_en while empty -> underflow = 1, dout_valid = 0. soft_rst at level 7 mid-packet -> level = 0, flags cleared, next packet reads correctly.
- Parametrisation: DATA_W = 16, DEPTH = 64, header 16'h0008 (length 2) -> 3 words after header, last flagged on third, full at 64.

Source files
------------

// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware FIFO between the router register block and one
// destination port. Each entry holds a DATA_W-bit byte plus a header-marker bit;
// the read side tracks packet length from headers and flags the final byte.
//
// Ports:
//   i_clk, i_rst (sync, active-high), i_soft_rst (sync flush)
//   write side : i_wr_en, i_lfd_state, i_d_in[DATA_W]
//   read side  : i_rd_en, o_dout[DATA_W], o_dout_valid, o_dout_last
//   status     : o_full, o_empty, o_almost_full, o_almost_empty,
//                o_level[ADDR_W+1], o_overflow, o_underflow
module router_fifo_pkt #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_soft_rst,
    input  logic              i_wr_en,
    input  logic              i_lfd_state,
    input  logic [DATA_W-1:0] i_d_in,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    output logic              o_dout_last,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [ADDR_W:0]   o_level,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned ENT_W = DATA_W + 1;

    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_rem;
    logic              r_lfd_q;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_dout_last;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_clr;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [PTR_W-1:0]  w_level;
    logic [ENT_W-1:0]  w_rd_word;
    logic              w_rd_hdr;

    // Status from pointer comparison; the extra MSB separates full from empty.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_clr     = i_rst || i_soft_rst;
    assign w_wr_acc  = i_wr_en && !w_full && !w_clr;
    assign w_rd_acc  = i_rd_en && !w_empty && !w_clr;
    assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign w_rd_hdr  = w_rd_word[DATA_W];

    // Storage array; contents are not reset, pointer reset makes them unreachable.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {r_lfd_q, i_d_in};
        end
    end

    // Pointers, packet tracking, read data and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_rem        <= '0;
            r_lfd_q      <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_lfd_q <= i_lfd_state;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
                r_dout       <= w_rd_word[DATA_W-1:0];
                r_dout_valid <= 1'b1;
                r_dout_last  <= !w_rd_hdr && (r_rem == DATA_W'(1));
                // Header reload counts payload bytes plus the trailing parity byte.
                if (w_rd_hdr) begin
                    r_rem <= DATA_W'(w_rd_word[DATA_W-1:2]) + DATA_W'(1);
                end else if (r_rem != '0) begin
                    r_rem <= r_rem - DATA_W'(1);
                end
            end else begin
                r_dout_valid <= 1'b0;
                r_dout_last  <= 1'b0;
            end
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (i_rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_dout         = r_dout;
    assign o_dout_valid   = r_dout_valid;
    assign o_dout_last    = r_dout_last;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_level        = w_level;
    assign o_almost_full  = (32'(w_level) >= AF_THRESH);
    assign o_almost_empty = (32'(w_level) <= AE_THRESH);
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed bench for router_fifo_pkt: a default 8x16 instance (a_*) and a
// 16x64 instance (b_*) sharing one clock.
module tb_router_fifo_pkt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W = 8, DEPTH = 16
    logic       a_rst, a_soft_rst, a_wr_en, a_lfd, a_rd_en;
    logic [7:0] a_din, a_dout;
    logic       a_valid, a_last, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [4:0] a_level;

    // Instance B: DATA_W = 16, DEPTH = 64
    logic        b_rst, b_soft_rst, b_wr_en, b_lfd, b_rd_en;
    logic [15:0] b_din, b_dout;
    logic        b_valid, b_last, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [6:0]  b_level;

    router_fifo_pkt u_a (
        .i_clk(clk), .i_rst(a_rst), .i_soft_rst(a_soft_rst), .i_wr_en(a_wr_en),
        .i_lfd_state(a_lfd), .i_d_in(a_din), .i_rd_en(a_rd_en), .o_dout(a_dout),
        .o_dout_valid(a_valid), .o_dout_last(a_last), .o_full(a_full),
        .o_empty(a_empty), .o_almost_full(a_af), .o_almost_empty(a_ae),
        .o_level(a_level), .o_overflow(a_ovf), .o_underflow(a_unf)
    );

    router_fifo_pkt #(.DATA_W(16), .DEPTH(64)) u_b (
        .i_clk(clk), .i_rst(b_rst), .i_soft_rst(b_soft_rst), .i_wr_en(b_wr_en),
        .i_lfd_state(b_lfd), .i_d_in(b_din), .i_rd_en(b_rd_en), .o_dout(b_dout),
        .o_dout_valid(b_valid), .o_dout_last(b_last), .o_full(b_full),
        .o_empty(b_empty), .o_almost_full(b_af), .o_almost_empty(b_ae),
        .o_level(b_level), .o_overflow(b_ovf), .o_underflow(b_unf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_b;

    initial begin
        a_rst = 1'b1; a_soft_rst = 1'b0; a_wr_en = 1'b0; a_lfd = 1'b0;
        a_din = '0;   a_rd_en = 1'b0;
        b_rst = 1'b1; b_soft_rst = 1'b0; b_wr_en = 1'b0; b_lfd = 1'b0;
        b_din = '0;   b_rd_en = 1'b0;
        step(); step();
        a_rst = 1'b0; b_rst = 1'b0;

        // ---- Reset mid-traffic ----
        a_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_din = 8'(8'h90 + i);
            step();
        end
        a_wr_en = 1'b0; a_rd_en = 1'b1;
        step();
        chk("pre_rst_dout", 32'(a_dout), 32'h90);
        a_rst = 1'b1; a_wr_en = 1'b1; a_din = 8'h55;
        step(); step();
        a_rst = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        chk("rst_dout",   32'(a_dout),  32'h0);
        chk("rst_valid",  32'(a_valid), 32'h0);
        chk("rst_last",   32'(a_last),  32'h0);
        chk("rst_level",  32'(a_level), 32'h0);
        chk("rst_ovf",    32'(a_ovf),   32'h0);
        chk("rst_unf",    32'(a_unf),   32'h0);
        chk("rst_empty",  32'(a_empty), 32'h1);
        chk("rst_full",   32'(a_full),  32'h0);
        chk("rst_ae",     32'(a_ae),    32'h1);
        chk("rst_af",     32'(a_af),    32'h0);

        // ---- Packet: header 0C (3 payload) + A1 A2 A3 + parity 5E ----
        a_lfd = 1'b1;
        step();
        a_lfd = 1'b0; a_wr_en = 1'b1; a_din = 8'h0C;
        step();
        chk("pkt_empty_fall", 32'(a_empty), 32'h0);
        a_din = 8'hA1; step();
        a_din = 8'hA2; step();
        a_din = 8'hA3; step();
        a_din = 8'h5E; step();
        a_wr_en = 1'b0;
        chk("pkt_level", 32'(a_level), 32'd5);
        a_rd_en = 1'b1;
        step(); chk("pkt_d0", 32'(a_dout), 32'h0C); chk("pkt_v0", 32'(a_valid), 1); chk("pkt_l0", 32'(a_last), 0);
        step(); chk("pkt_d1", 32'(a_dout), 32'hA1); chk("pkt_v1", 32'(a_valid), 1); chk("pkt_l1", 32'(a_last), 0);
        step(); chk("pkt_d2", 32'(a_dout), 32'hA2); chk("pkt_v2", 32'(a_valid), 1); chk("pkt_l2", 32'(a_last), 0);
        step(); chk("pkt_d3", 32'(a_dout), 32'hA3); chk("pkt_v3", 32'(a_valid), 1); chk("pkt_l3", 32'(a_last), 0);
        step(); chk("pkt_d4", 32'(a_dout), 32'h5E); chk("pkt_v4", 32'(a_valid), 1); chk("pkt_l4", 32'(a_last), 1);
        a_rd_en = 1'b0;
        step();
        chk("pkt_idle_valid", 32'(a_valid), 0);
        chk("pkt_idle_last",  32'(a_last),  0);
        chk("pkt_idle_hold",  32'(a_dout),  32'h5E);
        chk("pkt_idle_empty", 32'(a_empty), 1);

        // ---- Fill to 16, 17th write dropped ----
        a_wr_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            a_din = 8'(i + 15);
            step();
            chk($sformatf("fill_af_%0d", i),    32'(a_af),    32'(i >= 14));
            chk($sformatf("fill_full_%0d", i),  32'(a_full),  32'(i >= 16));
            chk($sformatf("fill_level_%0d", i), 32'(a_level), 32'((i > 16) ? 16 : i));
            chk($sformatf("fill_ovf_%0d", i),   32'(a_ovf),   32'(i == 17));
        end

        // ---- Simultaneous at full: read wins, write dropped ----
        a_rd_en = 1'b1; a_din = 8'hEE;
        step();
        a_wr_en = 1'b0;
        chk("simfull_dout",  32'(a_dout),  32'h10);
        chk("simfull_level", 32'(a_level), 32'd15);
        chk("simfull_full",  32'(a_full),  0);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("drain_%0d", i), 32'(a_dout), 32'(8'(i + 16)));
            chk($sformatf("drain_last_%0d", i), 32'(a_last), 0);
        end
        a_rd_en = 1'b0;
        step();
        chk("drain_empty", 32'(a_empty), 1);
        chk("drain_level", 32'(a_level), 0);

        // ---- Simultaneous at level 5 across the pointer wrap ----
        a_wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_din = 8'(48 + i);
            q.push_back(a_din);
            step();
        end
        chk("wrap_level_start", 32'(a_level), 5);
        a_rd_en = 1'b1;
        for (int i = 5; i < 17; i++) begin
            a_din = 8'(48 + i);
            q.push_back(a_din);
            step();
            exp_b = q.pop_front();
            chk($sformatf("wrap_dout_%0d", i),  32'(a_dout),  32'(exp_b));
            chk($sformatf("wrap_level_%0d", i), 32'(a_level), 5);
        end
        a_wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_b = q.pop_front();
            chk($sformatf("wrap_tail_%0d", i), 32'(a_dout), 32'(exp_b));
        end
        a_rd_en = 1'b0;
        step();
        chk("wrap_empty", 32'(a_empty), 1);

        // ---- Underflow ----
        a_rd_en = 1'b1;
        step();
        a_rd_en = 1'b0;
        chk("unf_flag",  32'(a_unf),   1);
        chk("unf_valid", 32'(a_valid), 0);

        // ---- soft_rst at level 7 mid-packet ----
        a_lfd = 1'b1;
        step();
        a_lfd = 1'b0; a_wr_en = 1'b1; a_din = 8'h14;
        step();
        for (int i = 0; i < 8; i++) begin
            a_din = 8'(8'h60 + i);
            step();
        end
        a_wr_en = 1'b0; a_rd_en = 1'b1;
        step(); step();
        a_rd_en = 1'b0;
        chk("srst_pre_level", 32'(a_level), 7);
        a_soft_rst = 1'b1; a_wr_en = 1'b1; a_rd_en = 1'b1; a_din = 8'hFF;
        step();
        a_soft_rst = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        chk("srst_level", 32'(a_level), 0);
        chk("srst_empty", 32'(a_empty), 1);
        chk("srst_unf",   32'(a_unf),   0);
        chk("srst_ovf",   32'(a_ovf),   0);
        chk("srst_valid", 32'(a_valid), 0);
        chk("srst_dout",  32'(a_dout),  0);
        a_lfd = 1'b1;
        step();
        a_lfd = 1'b0; a_wr_en = 1'b1; a_din = 8'h04;
        step();
        a_din = 8'h77; step();
        a_din = 8'h88; step();
        a_wr_en = 1'b0; a_rd_en = 1'b1;
        step(); chk("post_d0", 32'(a_dout), 32'h04); chk("post_l0", 32'(a_last), 0);
        step(); chk("post_d1", 32'(a_dout), 32'h77); chk("post_l1", 32'(a_last), 0);
        step(); chk("post_d2", 32'(a_dout), 32'h88); chk("post_l2", 32'(a_last), 1);
        a_rd_en = 1'b0;
        step();
        chk("post_valid", 32'(a_valid), 0);

        // ---- Instance B: 16-bit packet, header length 2 ----
        b_lfd = 1'b1;
        step();
        b_lfd = 1'b0; b_wr_en = 1'b1; b_din = 16'h0008;
        step();
        for (int k = 1; k <= 3; k++) begin
            b_din = 16'(16'hB000 + k);
            step();
        end
        b_wr_en = 1'b0; b_rd_en = 1'b1;
        step();
        chk("b_hdr",      32'(b_dout), 32'h0008);
        chk("b_hdr_last", 32'(b_last), 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("b_d%0d", k), 32'(b_dout), 32'(16'hB000 + k));
            chk($sformatf("b_l%0d", k), 32'(b_last), 32'(k == 3));
        end
        b_rd_en = 1'b0;
        step();
        chk("b_empty", 32'(b_empty), 1);

        // ---- Instance B: fill to 64 ----
        b_wr_en = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            b_din = 16'(i);
            step();
            if (i == 63) chk("b_full_63", 32'(b_full), 0);
        end
        chk("b_full_64",  32'(b_full),  1);
        chk("b_level_64", 32'(b_level), 64);
        chk("b_af_64",    32'(b_af),    1);
        step();
        b_wr_en = 1'b0;
        chk("b_ovf",      32'(b_ovf),   1);
        chk("b_level_hold", 32'(b_level), 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
